// File: rtl/dpwm_seq_ctrl.sv
// Run-time sequencer for the open-loop DPWM path: soft start, slew-limited run,
// ramp-down on stop, and fault shutdown with a restart holdoff.
module dpwm_seq_ctrl #(
    parameter int unsigned STEP_DIV = 200,
    parameter logic [7:0]  MAX_DUTY = 8'd230,
    parameter int unsigned HOLDOFF  = 20000
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_fault,
    input  logic [7:0] i_target_duty,
    input  logic [3:0] i_dt1_sel,
    input  logic [3:0] i_dt2_sel,
    output logic [7:0] o_duty_sel,
    output logic [3:0] o_dt1_sel,
    output logic [3:0] o_dt2_sel,
    output logic       o_dpwm_en,
    output logic       o_ramping,
    output logic       o_running,
    output logic       o_fault
);

    localparam int unsigned PW = $clog2(STEP_DIV);
    localparam int unsigned HW = $clog2(HOLDOFF);
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RAMP_UP    = 3'd1,
        RUN        = 3'd2,
        RAMP_DOWN  = 3'd3,
        FAULT_HOLD = 3'd4
    } state_t;

    function automatic logic [7:0] clamp_duty(input logic [7:0] req);
        if (req > MAX_DUTY) begin
            return MAX_DUTY;
        end else begin
            return req;
        end
    endfunction

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [HW-1:0] hold_r, hold_s;
    logic [7:0]    duty_r, duty_s;
    logic [3:0]    dt1_r, dt1_s, dt2_r, dt2_s;
    logic          en_r, en_s;
    logic          ramping_r, ramping_s;
    logic          running_r, running_s;
    logic          fault_r, fault_s;
    logic [7:0]    tgt_s;
    logic          tick_s;

    assign tgt_s  = clamp_duty(i_target_duty);
    assign tick_s = (presc_r == PRESC_MAX);

    // State register and all registered outputs.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            presc_r   <= '0;
            hold_r    <= '0;
            duty_r    <= 8'd0;
            dt1_r     <= 4'd0;
            dt2_r     <= 4'd0;
            en_r      <= 1'b0;
            ramping_r <= 1'b0;
            running_r <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            hold_r    <= hold_s;
            duty_r    <= duty_s;
            dt1_r     <= dt1_s;
            dt2_r     <= dt2_s;
            en_r      <= en_s;
            ramping_r <= ramping_s;
            running_r <= running_s;
            fault_r   <= fault_s;
        end
    end

    // Next-state, duty stepping, dead-time latch and output decode.
    always_comb begin
        state_s = state_r;
        duty_s  = duty_r;
        en_s    = en_r;
        dt1_s   = dt1_r;
        dt2_s   = dt2_r;
        hold_s  = '0;
        presc_s = '0;

        case (state_r)
            IDLE: begin
                duty_s = 8'd0;
                en_s   = 1'b0;
                if (i_fault) begin
                    state_s = FAULT_HOLD;
                end else if (i_start && !i_stop) begin
                    state_s = RAMP_UP;
                    dt1_s   = i_dt1_sel;
                    dt2_s   = i_dt2_sel;
                end else begin
                    state_s = IDLE;
                end
            end
            RAMP_UP: begin
                en_s = 1'b1;
                if (i_fault) begin
                    state_s = FAULT_HOLD;
                end else if (i_stop) begin
                    state_s = RAMP_DOWN;
                end else if (duty_r >= tgt_s) begin
                    state_s = RUN;
                end else if (tick_s) begin
                    duty_s = duty_r + 8'd1;
                end else begin
                    duty_s = duty_r;
                end
            end
            RUN: begin
                en_s = 1'b1;
                if (i_fault) begin
                    state_s = FAULT_HOLD;
                end else if (i_stop) begin
                    state_s = RAMP_DOWN;
                end else if (tick_s && (duty_r < tgt_s)) begin
                    duty_s = duty_r + 8'd1;
                end else if (tick_s && (duty_r > tgt_s)) begin
                    duty_s = duty_r - 8'd1;
                end else begin
                    duty_s = duty_r;
                end
            end
            RAMP_DOWN: begin
                en_s = 1'b1;
                if (i_fault) begin
                    state_s = FAULT_HOLD;
                end else if (duty_r == 8'd0) begin
                    state_s = IDLE;
                    en_s    = 1'b0;
                end else if (tick_s) begin
                    duty_s = duty_r - 8'd1;
                end else begin
                    duty_s = duty_r;
                end
            end
            FAULT_HOLD: begin
                // Holdoff only expires with fault gone and no pending start.
                if (i_fault) begin
                    hold_s = '0;
                end else if (hold_r == HOLD_MAX) begin
                    hold_s = hold_r;
                    if (!i_start) begin
                        state_s = IDLE;
                    end else begin
                        state_s = FAULT_HOLD;
                    end
                end else begin
                    hold_s = hold_r + {{(HW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                duty_s  = 8'd0;
                en_s    = 1'b0;
            end
        endcase

        if (state_s == FAULT_HOLD) begin
            duty_s = 8'd0;
            en_s   = 1'b0;
        end else begin
            hold_s = '0;
        end

        if ((state_s == state_r) &&
            ((state_r == RAMP_UP) || (state_r == RUN) || (state_r == RAMP_DOWN))) begin
            presc_s = tick_s ? '0 : presc_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            presc_s = '0;
        end

        ramping_s = (state_s == RAMP_UP) || (state_s == RAMP_DOWN);
        running_s = (state_s == RUN) && (duty_s == tgt_s);
        fault_s   = (state_s == FAULT_HOLD);
    end

    assign o_duty_sel = duty_r;
    assign o_dt1_sel  = dt1_r;
    assign o_dt2_sel  = dt2_r;
    assign o_dpwm_en  = en_r;
    assign o_ramping  = ramping_r;
    assign o_running  = running_r;
    assign o_fault    = fault_r;

endmodule

// File: tb/tb_dpwm_seq_ctrl.sv
// Self-checking bench for dpwm_seq_ctrl: vector table plus hand-written
// stop/fault/reset sequences, checked through an expected-result queue.
module tb_dpwm_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, fault;
    logic [7:0] tgt;
    logic [3:0] dt1, dt2;
    logic [7:0] duty_sel;
    logic [3:0] dt1_sel, dt2_sel;
    logic       dpwm_en, ramping, running, fault_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dpwm_seq_ctrl #(.STEP_DIV(4), .MAX_DUTY(8'd230), .HOLDOFF(16)) dut (
        .i_clk(clk), .reset(reset),
        .i_start(start), .i_stop(stop), .i_fault(fault),
        .i_target_duty(tgt), .i_dt1_sel(dt1), .i_dt2_sel(dt2),
        .o_duty_sel(duty_sel), .o_dt1_sel(dt1_sel), .o_dt2_sel(dt2_sel),
        .o_dpwm_en(dpwm_en), .o_ramping(ramping), .o_running(running),
        .o_fault(fault_o)
    );

    typedef struct {
        logic       start, stop, fault;
        logic [7:0] tgt;
        logic [3:0] dt1, dt2;
        int         ncyc;
        logic [7:0] e_duty;
        logic       e_en, e_ramp, e_run, e_fault;
        logic [3:0] e_dt1, e_dt2;
    } vec_t;

    vec_t exp_q[$];

    task automatic cmp(input string name, input int id, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, want %0d", name, id, act, want);
        end
    endtask

    task automatic check_outputs(input string tag, input int id);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s[%0d]: scoreboard empty", tag, id);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".duty"},    id, int'(duty_sel), int'(e.e_duty));
            cmp({tag, ".en"},      id, int'(dpwm_en),  int'(e.e_en));
            cmp({tag, ".ramping"}, id, int'(ramping),  int'(e.e_ramp));
            cmp({tag, ".running"}, id, int'(running),  int'(e.e_run));
            cmp({tag, ".fault"},   id, int'(fault_o),  int'(e.e_fault));
            cmp({tag, ".dt1"},     id, int'(dt1_sel),  int'(e.e_dt1));
            cmp({tag, ".dt2"},     id, int'(dt2_sel),  int'(e.e_dt2));
        end
    endtask

    // Drive one vector, queue its expectation, let ncyc edges pass, then compare.
    task automatic run_vec(input string tag, input int id, input vec_t v);
        start = v.start; stop = v.stop; fault = v.fault;
        tgt = v.tgt; dt1 = v.dt1; dt2 = v.dt2;
        exp_q.push_back(v);
        repeat (v.ncyc) @(posedge clk);
        #1;
        check_outputs(tag, id);
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; fault = 1'b0;
        tgt = 8'd0; dt1 = 4'd0; dt2 = 4'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        // start stop fault tgt dt1 dt2 ncyc | duty en ramp run fault dt1 dt2
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd10,  4'h3, 4'h5, 1,   8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'h5};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'd10,  4'h3, 4'h5, 1,   8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h5};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd10,  4'h3, 4'h5, 3,   8'd1,   1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h5};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'd10,  4'h3, 4'h5, 36,  8'd10,  1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h5};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'd10,  4'h3, 4'h5, 1,   8'd10,  1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h5};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'd10,  4'hA, 4'hA, 5,   8'd10,  1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h5};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd7,   4'hA, 4'hA, 3,   8'd9,   1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h5};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'd7,   4'hA, 4'hA, 4,   8'd8,   1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h5};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'd7,   4'hA, 4'hA, 4,   8'd7,   1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h5};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'd250, 4'hA, 4'hA, 4,   8'd8,   1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h5};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'd250, 4'hA, 4'hA, 888, 8'd230, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h5};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'd250, 4'hA, 4'hA, 8,   8'd230, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h5};

        // Reset values, checked while reset is still held.
        start = 1'b0; stop = 1'b0; fault = 1'b0;
        tgt = 8'd0; dt1 = 4'hF; dt2 = 4'hF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 4'h0, 0,
                          8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
        check_outputs("reset", 0);
        reset = 1'b0;

        // Soft start to 10, slew down to 7, clamp at MAX_DUTY, dt inputs ignored in RUN.
        for (int i = 0; i < 12; i++) begin
            run_vec("tbl", i, tbl[i]);
        end

        // Asynchronous reset in RUN: outputs clear with no clock edge.
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 4'h0, 0,
                          8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
        check_outputs("async_rst", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Start with stop held stays IDLE; then run at 5 and ramp down.
        run_vec("stop", 0, '{1'b1, 1'b1, 1'b0, 8'd5, 4'hA, 4'hA, 3,
                             8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
        run_vec("stop", 1, '{1'b1, 1'b0, 1'b0, 8'd5, 4'hA, 4'hA, 22,
                             8'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 4'hA});
        run_vec("stop", 2, '{1'b0, 1'b1, 1'b0, 8'd5, 4'h1, 4'h2, 1,
                             8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'hA});
        run_vec("stop", 3, '{1'b1, 1'b1, 1'b0, 8'd5, 4'h1, 4'h2, 4,
                             8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'hA});
        run_vec("stop", 4, '{1'b1, 1'b1, 1'b0, 8'd5, 4'h1, 4'h2, 16,
                             8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'hA});
        run_vec("stop", 5, '{1'b0, 1'b1, 1'b0, 8'd5, 4'h1, 4'h2, 1,
                             8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA});

        // Fault during RAMP_UP at duty 3, holdoff with start low.
        run_vec("fault", 0, '{1'b1, 1'b0, 1'b0, 8'd10, 4'h6, 4'h9, 1,
                              8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 4'h9});
        run_vec("fault", 1, '{1'b1, 1'b0, 1'b0, 8'd10, 4'h6, 4'h9, 12,
                              8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 4'h9});
        run_vec("fault", 2, '{1'b1, 1'b0, 1'b1, 8'd10, 4'h6, 4'h9, 1,
                              8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h9});
        run_vec("fault", 3, '{1'b0, 1'b0, 1'b0, 8'd10, 4'h6, 4'h9, 15,
                              8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h9});
        run_vec("fault", 4, '{1'b0, 1'b0, 1'b0, 8'd10, 4'h6, 4'h9, 1,
                              8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9});

        // Fault from IDLE, held start blocks exit, re-fault restarts holdoff.
        run_vec("hold", 0, '{1'b1, 1'b0, 1'b1, 8'd10, 4'h1, 4'h1, 1,
                             8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h9});
        run_vec("hold", 1, '{1'b1, 1'b0, 1'b0, 8'd10, 4'h1, 4'h1, 20,
                             8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h9});
        run_vec("hold", 2, '{1'b1, 1'b0, 1'b1, 8'd10, 4'h1, 4'h1, 1,
                             8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h9});
        run_vec("hold", 3, '{1'b0, 1'b0, 1'b0, 8'd10, 4'h1, 4'h1, 15,
                             8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h9});
        run_vec("hold", 4, '{1'b0, 1'b0, 1'b0, 8'd10, 4'h1, 4'h1, 1,
                             8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9});

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
